// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Round-robin arbiter and sequencer in front of the single-ported data memory.
// Requester 0 is the CPU load/store unit, requester 1 a secondary master
// (debug / DMA). One transaction is in flight at a time; each one produces
// exactly one registered response pulse to its owner, with an error flag when
// the memory fails to answer within TIMEOUT cycles.
//
// Ports
//   clock, resetN           clock (rising edge), asynchronous active-low reset
//   mXReqValid/Write/Addr/Data/Be   request from requester X (X = 0, 1)
//   mXReqReady              combinational accept for requester X
//   mXRespValid/Data/Error  registered one-cycle response to requester X
//   memAddress              word-aligned address of the current transaction
//   memStoreData/ByteEnable latched store data and byte enables
//   memStoreValid           store strobe (memory acts on its rising edge)
//   memLoadData/Valid       combinational read data from the memory
//   memStoreComplete        store done pulse from the memory
//   busy                    a transaction (or the post-store gap) is active
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        resetN,

    input  logic        m0ReqValid,
    input  logic        m0ReqWrite,
    input  logic [31:0] m0ReqAddr,
    input  logic [31:0] m0ReqData,
    input  logic [3:0]  m0ReqBe,
    output logic        m0ReqReady,
    output logic        m0RespValid,
    output logic [31:0] m0RespData,
    output logic        m0RespError,

    input  logic        m1ReqValid,
    input  logic        m1ReqWrite,
    input  logic [31:0] m1ReqAddr,
    input  logic [31:0] m1ReqData,
    input  logic [3:0]  m1ReqBe,
    output logic        m1ReqReady,
    output logic        m1RespValid,
    output logic [31:0] m1RespData,
    output logic        m1RespError,

    output logic [31:0] memAddress,
    output logic [31:0] memStoreData,
    output logic [3:0]  memByteEnable,
    output logic        memStoreValid,
    input  logic [31:0] memLoadData,
    input  logic        memLoadDataValid,
    input  logic        memStoreComplete,

    output logic        busy
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    // The counter holds the number of completed LOAD/STORE cycles; the cycle
    // in which it would step to TIMEOUT is the last one we wait.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        GAP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] tmo_cnt;

    logic          grant_sel;
    logic          accept;
    logic          sel_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_data;
    logic [3:0]    sel_be;
    logic          in_xfer;
    logic          load_done;
    logic          store_done;
    logic          timed_out;
    logic          resp_fire;

    // The byte offset is deliberately dropped; the memory is word addressed.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^sel_addr[1:0];

    // Arbitration and completion decode
    always_comb begin
        // With both requesting, the one that did not win last time goes next.
        grant_sel  = (m0ReqValid && m1ReqValid) ? ~last_grant : m1ReqValid;
        // Gated by resetN so nothing is accepted while reset is held.
        accept     = resetN && (state == IDLE) && (m0ReqValid || m1ReqValid);
        sel_write  = grant_sel ? m1ReqWrite : m0ReqWrite;
        sel_addr   = grant_sel ? m1ReqAddr  : m0ReqAddr;
        sel_data   = grant_sel ? m1ReqData  : m0ReqData;
        sel_be     = grant_sel ? m1ReqBe    : m0ReqBe;
        in_xfer    = (state == LOAD) || (state == STORE);
        load_done  = (state == LOAD)  && memLoadDataValid;
        store_done = (state == STORE) && memStoreComplete;
        timed_out  = in_xfer && !load_done && !store_done && (tmo_cnt >= TMO_LAST);
        resp_fire  = load_done || store_done || timed_out;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = sel_write ? STORE : LOAD;
                end
            end
            LOAD: begin
                if (load_done) begin
                    next_state = IDLE;
                end else if (timed_out) begin
                    next_state = GAP;
                end
            end
            STORE: begin
                if (store_done || timed_out) begin
                    next_state = GAP;
                end
            end
            // Strobe held low one extra cycle so the next store sees a fresh edge.
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign m0ReqReady    = accept && !grant_sel;
    assign m1ReqReady    = accept &&  grant_sel;
    assign memStoreValid = (state == STORE);
    assign busy          = (state != IDLE);

    // Control state
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                tmo_cnt    <= '0;
            end else if (in_xfer && (tmo_cnt != TMO_MAX)) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
        end
    end

    // Request latch: memory-side address/data hold until the next accept
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            memAddress    <= '0;
            memStoreData  <= '0;
            memByteEnable <= '0;
        end else if (accept) begin
            memAddress    <= {sel_addr[31:2], 2'b00};
            memStoreData  <= sel_data;
            memByteEnable <= sel_be;
        end
    end

    // Response stage: one-cycle pulse to the owner only, zero everywhere else
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m0RespValid <= 1'b0;
            m0RespError <= 1'b0;
            m0RespData  <= '0;
            m1RespValid <= 1'b0;
            m1RespError <= 1'b0;
            m1RespData  <= '0;
        end else begin
            m0RespValid <= resp_fire && !owner;
            m0RespError <= timed_out && !owner;
            m0RespData  <= (load_done && !owner) ? memLoadData : '0;
            m1RespValid <= resp_fire && owner;
            m1RespError <= timed_out && owner;
            m1RespData  <= (load_done && owner) ? memLoadData : '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter (TIMEOUT = 4). A transaction-level model
// predicts every DUT output on every falling edge; directed sections add
// hand-computed literal expectations for reset, a load, a store, fairness,
// back-to-back stores, timeout and reset during a store.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int TO = 4;

    logic        clock  = 1'b0;
    logic        resetN = 1'b0;

    logic        m0ReqValid = 1'b0, m0ReqWrite = 1'b0;
    logic [31:0] m0ReqAddr  = '0,   m0ReqData  = '0;
    logic [3:0]  m0ReqBe    = '0;
    logic        m1ReqValid = 1'b0, m1ReqWrite = 1'b0;
    logic [31:0] m1ReqAddr  = '0,   m1ReqData  = '0;
    logic [3:0]  m1ReqBe    = '0;

    logic        m0ReqReady, m0RespValid, m0RespError;
    logic        m1ReqReady, m1RespValid, m1RespError;
    logic [31:0] m0RespData, m1RespData;
    logic [31:0] memAddress, memStoreData;
    logic [3:0]  memByteEnable;
    logic        memStoreValid, busy;

    logic [31:0] memLoadData      = 32'hDEAD_BEEF;
    logic        memLoadDataValid = 1'b1;
    logic        memStoreComplete = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit store_auto = 1'b1;

    // Observations of the DUT, one entry/increment per falling edge
    int grant_log[$];
    bit sv_hist[$];
    int busy_cnt  = 0;
    int resp_cnt0 = 0;
    int resp_cnt1 = 0;

    // Transaction-level model
    bit          m_active = 0, m_store = 0, m_gap = 0;
    int          m_owner = 0, m_age = 0, m_last = 1;
    logic [31:0] m_addr = '0, m_sdata = '0;
    logic [3:0]  m_be = '0;
    bit          p_valid = 0, p_err = 0;
    int          p_owner = 0;
    logic [31:0] p_data = '0;

    dmem_arbiter #(.TIMEOUT(TO)) dut (
        .clock            (clock),
        .resetN           (resetN),
        .m0ReqValid       (m0ReqValid),
        .m0ReqWrite       (m0ReqWrite),
        .m0ReqAddr        (m0ReqAddr),
        .m0ReqData        (m0ReqData),
        .m0ReqBe          (m0ReqBe),
        .m0ReqReady       (m0ReqReady),
        .m0RespValid      (m0RespValid),
        .m0RespData       (m0RespData),
        .m0RespError      (m0RespError),
        .m1ReqValid       (m1ReqValid),
        .m1ReqWrite       (m1ReqWrite),
        .m1ReqAddr        (m1ReqAddr),
        .m1ReqData        (m1ReqData),
        .m1ReqBe          (m1ReqBe),
        .m1ReqReady       (m1ReqReady),
        .m1RespValid      (m1RespValid),
        .m1RespData       (m1RespData),
        .m1RespError      (m1RespError),
        .memAddress       (memAddress),
        .memStoreData     (memStoreData),
        .memByteEnable    (memByteEnable),
        .memStoreValid    (memStoreValid),
        .memLoadData      (memLoadData),
        .memLoadDataValid (memLoadDataValid),
        .memStoreComplete (memStoreComplete),
        .busy             (busy)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, want $finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Memory: completes a store one cycle after it first sees the strobe high.
    initial begin : mem_model
        bit nxt;
        forever begin
            @(negedge clock);
            nxt = store_auto && memStoreValid && !memStoreComplete;
            @(posedge clock);
            #1 memStoreComplete = nxt;
        end
    end

    task automatic model_step();
        bit          idle;
        int          g;
        bit          w;
        logic [31:0] a, d;
        logic [3:0]  be;
        idle = !m_active && !m_gap;
        g = -1;
        if (idle) begin
            if (m0ReqValid && m1ReqValid) g = 1 - m_last;
            else if (m0ReqValid)          g = 0;
            else if (m1ReqValid)          g = 1;
        end
        check("ready0",        32'(m0ReqReady),    32'(g == 0));
        check("ready1",        32'(m1ReqReady),    32'(g == 1));
        check("busy",          32'(busy),          32'(!idle));
        check("storeValid",    32'(memStoreValid), 32'(m_active && m_store));
        check("memAddress",    memAddress,         m_addr);
        check("memStoreData",  memStoreData,       m_sdata);
        check("memByteEnable", 32'(memByteEnable), 32'(m_be));
        check("resp0Valid",    32'(m0RespValid),   32'(p_valid && p_owner == 0));
        check("resp0Data",     m0RespData,         (p_valid && p_owner == 0) ? p_data : 32'h0);
        check("resp0Error",    32'(m0RespError),   32'(p_valid && p_owner == 0 && p_err));
        check("resp1Valid",    32'(m1RespValid),   32'(p_valid && p_owner == 1));
        check("resp1Data",     m1RespData,         (p_valid && p_owner == 1) ? p_data : 32'h0);
        check("resp1Error",    32'(m1RespError),   32'(p_valid && p_owner == 1 && p_err));

        // Advance to the next cycle
        p_valid = 0;
        p_err   = 0;
        p_data  = '0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_active) begin
            m_age++;
            if (m_store && memStoreComplete) begin
                p_valid = 1; p_owner = m_owner; m_active = 0; m_gap = 1;
            end else if (!m_store && memLoadDataValid) begin
                p_valid = 1; p_owner = m_owner; p_data = memLoadData; m_active = 0;
            end else if (m_age >= TO) begin
                p_valid = 1; p_owner = m_owner; p_err = 1; m_active = 0; m_gap = 1;
            end
        end else if (g >= 0) begin
            w  = (g == 0) ? m0ReqWrite : m1ReqWrite;
            a  = (g == 0) ? m0ReqAddr  : m1ReqAddr;
            d  = (g == 0) ? m0ReqData  : m1ReqData;
            be = (g == 0) ? m0ReqBe    : m1ReqBe;
            m_addr   = {a[31:2], 2'b00};
            m_sdata  = d;
            m_be     = be;
            m_owner  = g;
            m_last   = g;
            m_store  = w;
            m_age    = 0;
            m_active = 1;
        end
    endtask

    // Compare process
    initial forever begin
        @(negedge clock);
        if (m0ReqReady) grant_log.push_back(0);
        if (m1ReqReady) grant_log.push_back(1);
        sv_hist.push_back(memStoreValid);
        if (busy)        busy_cnt++;
        if (m0RespValid) resp_cnt0++;
        if (m1RespValid) resp_cnt1++;
        if (!resetN) begin
            m_active = 0; m_gap = 0; m_last = 1; m_age = 0;
            m_addr = '0; m_sdata = '0; m_be = '0;
            p_valid = 0; p_err = 0; p_data = '0;
            check("rst ready0",     32'(m0ReqReady),    32'h0);
            check("rst ready1",     32'(m1ReqReady),    32'h0);
            check("rst busy",       32'(busy),          32'h0);
            check("rst storeValid", 32'(memStoreValid), 32'h0);
            check("rst memAddress", memAddress,         32'h0);
            check("rst storeData",  memStoreData,       32'h0);
            check("rst byteEnable", 32'(memByteEnable), 32'h0);
            check("rst resp0",      {m0RespData[30:0], m0RespValid} | 32'(m0RespError), 32'h0);
            check("rst resp1",      {m1RespData[30:0], m1RespValid} | 32'(m1RespError), 32'h0);
        end else begin
            model_step();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int m, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int acc);
        bit got;
        got = 0;
        acc = -1;
        if (m == 0) begin
            m0ReqValid = 1; m0ReqWrite = w; m0ReqAddr = a; m0ReqData = d; m0ReqBe = be;
        end else begin
            m1ReqValid = 1; m1ReqWrite = w; m1ReqAddr = a; m1ReqData = d; m1ReqBe = be;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if ((m == 0 && m0ReqReady) || (m == 1 && m1ReqReady)) begin
                got = 1;
                acc = cyc;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept m%0d: no ReqReady within 50 cycles, want an accept", m);
        end
        @(posedge clock);
        #1;
        if (m == 0) m0ReqValid = 0;
        else        m1ReqValid = 0;
    endtask

    initial begin
        int acc, a1, a2, b0, r0, r1, h0;
        int rises, low, minlow;
        bit seen;

        // Reset held with both requesters asking
        m0ReqValid = 1;
        m1ReqValid = 1;
        repeat (3) @(negedge clock);
        check("reset memAddress", memAddress, 32'h0);
        check("reset ready0",     32'(m0ReqReady), 32'h0);
        check("reset ready1",     32'(m1ReqReady), 32'h0);
        check("reset busy",       32'(busy), 32'h0);
        @(posedge clock);
        #1 resetN = 1;
        @(negedge clock);
        check("first ready0", 32'(m0ReqReady), 32'h1);
        check("first ready1", 32'(m1ReqReady), 32'h0);
        step();
        m0ReqValid = 0;
        m1ReqValid = 0;
        repeat (3) step();

        // m0 load
        memLoadData = 32'hDEAD_BEEF;
        issue(0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, acc);
        @(negedge clock);
        check("load memAddress", memAddress, 32'h0000_0104);
        @(negedge clock);
        check("load m0RespValid", 32'(m0RespValid), 32'h1);
        check("load m0RespData",  m0RespData, 32'hDEAD_BEEF);
        check("load m0RespError", 32'(m0RespError), 32'h0);
        check("load m1RespValid", 32'(m1RespValid), 32'h0);
        step();

        // m1 store
        b0 = busy_cnt;
        r1 = resp_cnt1;
        h0 = sv_hist.size();
        issue(1, 1'b1, 32'h0000_0202, 32'h1122_3344, 4'b0011, acc);
        @(negedge clock);
        check("store memAddress",    memAddress, 32'h0000_0200);
        check("store storeValid",    32'(memStoreValid), 32'h1);
        check("store memStoreData",  memStoreData, 32'h1122_3344);
        check("store memByteEnable", 32'(memByteEnable), 32'h3);
        repeat (2) @(negedge clock);
        check("store m1RespValid", 32'(m1RespValid), 32'h1);
        check("store m1RespData",  m1RespData, 32'h0);
        check("store m0RespValid", 32'(m0RespValid), 32'h0);
        repeat (3) @(negedge clock);
        step();
        check("store busy cycles", 32'(busy_cnt - b0), 32'd3);
        check("store responses",   32'(resp_cnt1 - r1), 32'd1);
        rises = 0;
        for (int i = h0; i < sv_hist.size(); i++)
            if (sv_hist[i] && !sv_hist[i-1]) rises++;
        check("store strobe edges", 32'(rises), 32'd1);

        // Fairness: both requesters load continuously
        m0ReqWrite = 0; m0ReqAddr = 32'h10;
        m1ReqWrite = 0; m1ReqAddr = 32'h20;
        memLoadData = 32'h0BAD_CAFE;
        grant_log.delete();
        m0ReqValid = 1;
        m1ReqValid = 1;
        repeat (8) @(negedge clock);
        step();
        m0ReqValid = 0;
        m1ReqValid = 0;
        check("fair grant count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check("fair grant order", 32'(grant_log[i]), 32'(i % 2));
        repeat (2) step();

        // Back-to-back stores from m0, the second with no byte enables
        h0 = sv_hist.size();
        r0 = resp_cnt0;
        issue(0, 1'b1, 32'h0000_0300, 32'hAAAA_5555, 4'hF, a1);
        issue(0, 1'b1, 32'h0000_0306, 32'h5555_AAAA, 4'h0, a2);
        repeat (7) step();
        rises  = 0;
        low    = 0;
        minlow = 1000;
        seen   = 0;
        for (int i = h0; i < sv_hist.size(); i++) begin
            if (sv_hist[i]) begin
                if (!sv_hist[i-1]) begin
                    rises++;
                    if (seen && low < minlow) minlow = low;
                end
                seen = 1;
                low  = 0;
            end else begin
                low++;
            end
        end
        check("b2b strobe edges",   32'(rises), 32'd2);
        check("b2b low gap >= 2",   32'(minlow >= 2), 32'h1);
        check("b2b responses",      32'(resp_cnt0 - r0), 32'd2);
        check("b2b second accept",  32'(a2 > a1), 32'h1);

        // Timeout on a store that never completes; m0 waits meanwhile
        store_auto = 0;
        issue(1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, acc);
        m0ReqWrite = 0;
        m0ReqAddr  = 32'h0000_0500;
        m0ReqValid = 1;
        repeat (5) @(negedge clock);
        check("tmo m1RespValid", 32'(m1RespValid), 32'h1);
        check("tmo m1RespError", 32'(m1RespError), 32'h1);
        check("tmo m1RespData",  m1RespData, 32'h0);
        check("tmo gap busy",    32'(busy), 32'h1);
        check("tmo gap strobe",  32'(memStoreValid), 32'h0);
        check("tmo gap ready0",  32'(m0ReqReady), 32'h0);
        @(negedge clock);
        check("tmo idle ready0", 32'(m0ReqReady), 32'h1);
        check("tmo idle busy",   32'(busy), 32'h0);
        step();
        m0ReqValid = 0;
        repeat (3) step();

        // Reset asserted while a store is in progress
        r0 = resp_cnt0;
        r1 = resp_cnt1;
        issue(0, 1'b1, 32'h0000_0600, 32'h0BAD_F00D, 4'hF, acc);
        check("pre-reset strobe", 32'(memStoreValid), 32'h1);
        resetN = 0;
        #1;
        check("reset drops strobe", 32'(memStoreValid), 32'h0);
        check("reset drops busy",   32'(busy), 32'h0);
        repeat (2) step();
        resetN = 1;
        repeat (6) step();
        check("no resp after reset m0", 32'(resp_cnt0 - r0), 32'd0);
        check("no resp after reset m1", 32'(resp_cnt1 - r1), 32'd0);
        store_auto = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
